karatsuba_mul_sched: RTL and testbench
======================================

Name: karatsuba_mul_sched

Overview:
- Sequencing controller for a single-level, two-way Karatsuba GF(2)[x] (carry-less) multiplier of N×N bits.
- Time-multiplexes one shared half-width, digit-serial carry-less multiplier core over the three sub-products: low·low, high·high and (low^high)·(low^high).
- XOR-combines the three sub-products into the 2N-bit result.
- Sits between the field-arithmetic front end (valid/ready operand stream) and result consumers, and replaces three parallel sub-multipliers with one.

Parameters:
- N, 571, operand width in bits.
- DIGIT, 1, operand-b bits consumed per cycle by the shared core; legal range 1..L.
- L (localparam), N - N/2, low-half width; 286 at default.
- HW (localparam), N/2, high-half width; 285 at default.
- K (localparam), ceil(L/DIGIT), cycles per sub-product; 286 at default.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, operands a/b are valid.
- in_ready, output, 1, block can accept operands.
- a, input, N, operand A.
- b, input, N, operand B.
- out_valid, output, 1, c holds a finished product.
- out_ready, input, 1, consumer takes c.
- c, output, 2N, carry-less product a·b; c[2N-1] is always 0.
- busy, output, 1, a multiplication is in flight (state not IDLE).

Behaviour:
- Reset (asynchronous, active-high): state IDLE, in_ready=1, out_valid=0, busy=0, c=0, all internal accumulators and counters cleared.
- Reset asserted mid-operation aborts the operation; no partial result ever appears on c.
- Operand split: a0=a[L-1:0], a1=a[N-1:L] zero-extended to L bits; b0 and b1 split the same way.
- Sub-products, each 2L-1 bits:
  - P0 = a0·b0
  - P2 = a1·b1
  - PM = (a0^a1)·(b0^b1)
- Combine (all XOR, no carries): c = (P2 << 2L) ^ ((PM^P0^P2) << L) ^ P0, truncated to 2N bits.
- FSM states: IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register a0, a1, b0, b1 and go to MUL_LO.
  - MUL_LO, MUL_HI, MUL_MID: each lasts exactly K cycles. The core is started on the first cycle and its result is stored in P0, P2 or PM on the last cycle. A digit counter runs 0..K-1 and wraps to 0 on each state exit.
  - COMBINE: one cycle; computes and registers c.
  - DONE: out_valid=1 and c held stable. When out_valid&&out_ready, go to IDLE; out_valid drops on the next edge.
- Latency: out_valid rises exactly 3K+2 rising edges after the accepting edge (860 at default). The result holds indefinitely under back-pressure.
- in_ready=0 in every state except IDLE. There is no input buffering and no overlap between operations.
- A new operand pair offered in the same cycle that DONE is handshaken is not accepted; it is taken on the following cycle, in IDLE.
- Core interface is internal: start pulse, x (L bits), y (L bits), done pulse after K cycles, p (2L-1 bits).
- Zero operands run the full sequence with no shortcut, so latency is constant.

Optional Feature:
- Macro: KARATSUBA_SCHED_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in any state other than IDLE returns the FSM to IDLE on the next edge.
  - abort forces out_valid=0 on that edge and clears the core and counters.
  - c keeps its previous value.
  - abort in IDLE has no effect; abort takes priority over in_valid in the same cycle.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Shared package karatsuba_pkg:
  - state enum
  - function clmul_ref (bitwise carry-less reference multiply, for the bench and assertions)
  - helper function ceil_div for deriving K
- Sub-module gf2_digit_serial_mul(W=L, DIGIT):
  - shift-and-XOR accumulator with a start/done handshake
  - instantiated once inside the controller

Test Plan:
- Default N=571, a=1, b=1 → after 860 cycles out_valid=1, c=1.
- a=1<<570, b=1<<570 → c=1<<1140; exercises the high-half path and the zero-extension of a1/b1.
- N=8, DIGIT=1: a=8'hFF, b=8'hFF → c=16'h5555. Also a=8'h03, b=8'h03 → c=16'h0005 (no carry).
- Back-pressure: hold out_ready=0 for 50 cycles after out_valid → c stable, in_ready=0 throughout. Then out_ready=1 → IDLE and in_ready=1 the next cycle.
- Reset mid-MUL_HI: assert rst at cycle 400 → out_valid=0 and in_ready=1 immediately. The next operation with a=5, b=7 returns c=27 (0x1B), with no stale data.
- 1000 random N=571 pairs with DIGIT ∈ {1, 8, 32}, random out_ready → every c equals clmul_ref(a, b), and every latency is 3K+2.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// +------------------------------------------------------------------------+
// | Module   : karatsuba_pkg                                               |
// | Purpose  : Shared definitions for the Karatsuba carry-less multiplier  |
// |            scheduler: FSM state encoding, ceil_div used to derive the  |
// |            per-sub-product cycle count, and clmul_ref, a plain         |
// |            shift-and-XOR reference multiply (up to CLMUL_W bits).      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

package karatsuba_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL_LO   = 3'd1,
      MUL_HI   = 3'd2,
      MUL_MID  = 3'd3,
      COMBINE  = 3'd4,
      DONE     = 3'd5
   } state_e;

   // Widest operand the reference multiply handles; narrower operands are
   // simply zero-extended by the caller.
   localparam int CLMUL_W = 571;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Schoolbook carry-less product, deliberately independent of the
   // Karatsuba split so it can serve as an oracle.
   function automatic logic [2*CLMUL_W-1:0] clmul_ref(input logic [CLMUL_W-1:0] x,
                                                      input logic [CLMUL_W-1:0] y);
      logic [2*CLMUL_W-1:0] r;
      r = '0;
      for (int i = 0; i < CLMUL_W; i++) begin
         if (y[i]) r = r ^ ((2*CLMUL_W)'(x) << i);
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/karatsuba_mul_sched_gf2_digit_serial_mul.sv
// +------------------------------------------------------------------------+
// | Module   : gf2_digit_serial_mul                                        |
// | Purpose  : Digit-serial GF(2)[x] multiplier, W x W -> 2W-1 bits.       |
// |            Consumes DIGIT bits of y per cycle, most significant digit  |
// |            first (Horner form), K = ceil(W/DIGIT) cycles per product.  |
// | Ports    : clk, rst   - clock, async active-high reset                 |
// |            clr        - synchronous flush of counter and accumulator   |
// |            start      - first cycle of a product (digit 0 processed)   |
// |            x, y       - operands, held stable by the caller for K cyc  |
// |            done       - high in the last cycle; p is final that cycle  |
// |            p          - product (combinational view of the next acc)   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module gf2_digit_serial_mul
   import karatsuba_pkg::*;
#(
   parameter int W     = 286,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           start,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic           done,
   output logic [2*W-2:0] p
);

   localparam int K  = ceil_div(W, DIGIT);
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = 2 * W - 1;
   localparam int YW = K * DIGIT;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [PW-1:0]    acc_q, acc_d;

   logic             w_active;
   logic             w_last;
   logic [CW-1:0]    w_idx;
   logic [31:0]      w_sh;
   logic [YW-1:0]    w_y_pad;
   logic [DIGIT-1:0] w_dig;
   logic [PW-1:0]    w_acc_next;

   always_comb begin
      w_active = start | run_q;
      // The start cycle is always digit 0 regardless of any stale count.
      w_idx    = start ? '0 : cnt_q;
      w_last   = (w_idx == CW'(K - 1));
      w_y_pad  = YW'(y);
      w_sh     = 32'((K - 1 - int'(w_idx)) * DIGIT);
      w_dig    = DIGIT'(w_y_pad >> w_sh);

      // Intermediate products are prefixes of x*y, so PW bits never overflow.
      w_acc_next = start ? '0 : (acc_q << DIGIT);
      for (int j = 0; j < DIGIT; j++) begin
         if (w_dig[j]) w_acc_next = w_acc_next ^ (PW'(x) << j);
      end

      cnt_d = cnt_q;
      run_d = run_q;
      acc_d = acc_q;
      if (clr) begin
         cnt_d = '0;
         run_d = 1'b0;
         acc_d = '0;
      end else if (w_active) begin
         acc_d = w_acc_next;
         if (w_last) begin
            cnt_d = '0;
            run_d = 1'b0;
         end else begin
            cnt_d = w_idx + CW'(1);
            run_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
         acc_q <= acc_d;
      end
   end

   assign done = w_active & w_last & ~clr;
   assign p    = w_acc_next;

endmodule

`default_nettype wire

// File: rtl/karatsuba_mul_sched.sv
// +------------------------------------------------------------------------+
// | Module   : karatsuba_mul_sched                                         |
// | Purpose  : One-level Karatsuba N x N carry-less multiplier that runs   |
// |            the three half-width sub-products (lo*lo, hi*hi, mid*mid)   |
// |            sequentially on one shared digit-serial core, then XOR-     |
// |            combines them into the 2N-bit product.                      |
// | Ports    : clk, rst            - clock, async active-high reset        |
// |            in_valid/in_ready   - operand handshake (a, b)              |
// |            out_valid/out_ready - result handshake (c)                  |
// |            c                   - product, held while out_valid         |
// |            busy                - operation in flight (state != IDLE)   |
// |            abort               - only with KARATSUBA_SCHED_ABORT_EN:   |
// |                                  return to IDLE, keep c                |
// | Latency  : out_valid rises 3K+2 edges after the accepting edge,        |
// |            K = ceil(L/DIGIT), L = N - N/2.                             |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module karatsuba_mul_sched
   import karatsuba_pkg::*;
#(
   parameter int N     = 571,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
`ifdef KARATSUBA_SCHED_ABORT_EN
   input  logic           abort,
`endif
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] c,
   output logic           busy
);

   localparam int L  = N - N / 2;
   localparam int HW = N / 2;
   localparam int PW = 2 * L - 1;
   localparam int XW = 4 * L;
   localparam int CN = 2 * N;

   state_e        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          start_q, start_d;
   logic [L-1:0]  a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
   logic [PW-1:0] p0_q, p0_d, p2_q, p2_d, pm_q, pm_d;
   logic [CN-1:0] c_q, c_d;

   logic [HW-1:0] w_a_hi, w_b_hi;
   logic [L-1:0]  w_x, w_y;
   logic [PW-1:0] w_core_p, w_mid;
   logic          w_core_done;
   logic          w_abort_req;
   logic          w_abort_hit;

`ifdef KARATSUBA_SCHED_ABORT_EN
   assign w_abort_req = abort;
`else
   assign w_abort_req = 1'b0;
`endif

   assign w_a_hi      = a[N-1:L];
   assign w_b_hi      = b[N-1:L];
   assign w_abort_hit = w_abort_req & (state_q != IDLE);
   // Middle term of Karatsuba: PM - P0 - P2, all subtraction being XOR.
   assign w_mid       = pm_q ^ p0_q ^ p2_q;

   // Operands for the shared core follow the current sub-product state.
   always_comb begin
      w_x = '0;
      w_y = '0;
      case (state_q)
         MUL_LO:  begin w_x = a0_q;        w_y = b0_q;        end
         MUL_HI:  begin w_x = a1_q;        w_y = b1_q;        end
         MUL_MID: begin w_x = a0_q ^ a1_q; w_y = b0_q ^ b1_q; end
         default: begin w_x = '0;          w_y = '0;          end
      endcase
   end

   gf2_digit_serial_mul #(
      .W     (L),
      .DIGIT (DIGIT)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_abort_hit),
      .start (start_q),
      .x     (w_x),
      .y     (w_y),
      .done  (w_core_done),
      .p     (w_core_p)
   );

   always_comb begin
      state_d = state_q;
      a0_d    = a0_q;
      a1_d    = a1_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      p0_d    = p0_q;
      p2_d    = p2_q;
      pm_d    = pm_q;
      c_d     = c_q;

      case (state_q)
         IDLE: begin
            // abort wins over a simultaneous operand offer
            if (in_valid && in_ready_q && !w_abort_req) begin
               a0_d    = a[L-1:0];
               a1_d    = L'(w_a_hi);
               b0_d    = b[L-1:0];
               b1_d    = L'(w_b_hi);
               state_d = MUL_LO;
            end
         end
         MUL_LO: begin
            if (w_core_done) begin
               p0_d    = w_core_p;
               state_d = MUL_HI;
            end
         end
         MUL_HI: begin
            if (w_core_done) begin
               p2_d    = w_core_p;
               state_d = MUL_MID;
            end
         end
         MUL_MID: begin
            if (w_core_done) begin
               pm_d    = w_core_p;
               state_d = COMBINE;
            end
         end
         COMBINE: begin
            c_d     = CN'((XW'(p2_q) << (2 * L)) ^ (XW'(w_mid) << L) ^ XW'(p0_q));
            state_d = DONE;
         end
         DONE: begin
            if (out_valid_q && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (w_abort_hit) begin
         state_d = IDLE;
         c_d     = c_q;
      end

      // Core start pulse on the first cycle of each sub-product state.
      start_d     = !w_abort_hit && (state_d != state_q) &&
                    (state_d == MUL_LO || state_d == MUL_HI || state_d == MUL_MID);
      // out_valid follows one cycle behind DONE entry, giving 3K+2 latency.
      out_valid_d = !w_abort_hit && (state_q == DONE) && !(out_valid_q && out_ready);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         a0_q        <= '0;
         a1_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         p0_q        <= '0;
         p2_q        <= '0;
         pm_q        <= '0;
         c_q         <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         a0_q        <= a0_d;
         a1_q        <= a1_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         p0_q        <= p0_d;
         p2_q        <= p2_d;
         pm_q        <= pm_d;
         c_q         <= c_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign c         = c_q;

endmodule

`default_nettype wire

// File: tb/tb_karatsuba_mul_sched.sv
// +------------------------------------------------------------------------+
// | Module   : tb_karatsuba_mul_sched                                      |
// | Purpose  : Scoreboard bench for karatsuba_mul_sched. Three instances:  |
// |            N=571/DIGIT=1 (latency 860), N=571/DIGIT=32 (latency 29)    |
// |            and N=8/DIGIT=1 (latency 14). Stimulus pushes expected      |
// |            products; per-instance monitors pop on each new output.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_karatsuba_mul_sched;
   import karatsuba_pkg::*;

   localparam int NB = 571;
   localparam int NS = 8;
   localparam int W2 = 2 * NB;
   localparam longint LAT_D1  = 860;   // K=286
   localparam longint LAT_D32 = 29;    // K=ceil(286/32)=9
   localparam longint LAT_N8  = 14;    // L=4, K=4

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          d1_in_valid = 1'b0, d1_out_ready = 1'b1;
   logic [NB-1:0] d1_a = '0, d1_b = '0;
   logic          d1_in_ready, d1_out_valid, d1_busy;
   logic [W2-1:0] d1_c;

   logic          d32_in_valid = 1'b0, d32_out_ready = 1'b1;
   logic [NB-1:0] d32_a = '0, d32_b = '0;
   logic          d32_in_ready, d32_out_valid, d32_busy;
   logic [W2-1:0] d32_c;
   logic          d32_rand_rdy = 1'b0;

   logic            n8_in_valid = 1'b0, n8_out_ready = 1'b1;
   logic [NS-1:0]   n8_a = '0, n8_b = '0;
   logic            n8_in_ready, n8_out_valid, n8_busy;
   logic [2*NS-1:0] n8_c;

   karatsuba_mul_sched #(.N(NB), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst),
`ifdef KARATSUBA_SCHED_ABORT_EN
      .abort(1'b0),
`endif
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .a(d1_a), .b(d1_b),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .c(d1_c), .busy(d1_busy));

   karatsuba_mul_sched #(.N(NB), .DIGIT(32)) u_d32 (
      .clk(clk), .rst(rst),
`ifdef KARATSUBA_SCHED_ABORT_EN
      .abort(1'b0),
`endif
      .in_valid(d32_in_valid), .in_ready(d32_in_ready), .a(d32_a), .b(d32_b),
      .out_valid(d32_out_valid), .out_ready(d32_out_ready), .c(d32_c), .busy(d32_busy));

   karatsuba_mul_sched #(.N(NS), .DIGIT(1)) u_n8 (
      .clk(clk), .rst(rst),
`ifdef KARATSUBA_SCHED_ABORT_EN
      .abort(1'b0),
`endif
      .in_valid(n8_in_valid), .in_ready(n8_in_ready), .a(n8_a), .b(n8_b),
      .out_valid(n8_out_valid), .out_ready(n8_out_ready), .c(n8_c), .busy(n8_busy));

   // ---------------------------------------------------------------- helpers
   function automatic string shorten(input string s);
      if (s.len() > 200) return {s.substr(0, 99), "..", s.substr(s.len() - 100, s.len() - 1)};
      return s;
   endfunction

   task automatic check(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %s expected %s", name,
                  shorten($sformatf("%0h", act)), shorten($sformatf("%0h", exp)));
      end
   endtask

   task automatic fail(input string name, input string why);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", name, why);
   endtask

   function automatic logic [NB-1:0] bitn(input int i);
      logic [NB-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [W2-1:0] bit2(input int i);
      logic [W2-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [NB-1:0] rand_op();
      logic [NB-1:0] r;
      for (int k = 0; k < NB; k++) r[k] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   // --------------------------------------------------------------- monitors
   logic [W2-1:0] d1_exp_q[$], d32_exp_q[$], n8_exp_q[$];
   longint        d1_acc_q[$], d32_acc_q[$], n8_acc_q[$];
   logic          d1_ov_prev = 1'b0, d32_ov_prev = 1'b0, n8_ov_prev = 1'b0;
   logic [W2-1:0] d1_hold = '0;

   always @(negedge clk) begin
      if (rst) begin
         d1_acc_q.delete();
         d1_ov_prev = 1'b0;
      end else begin
         if (d1_in_valid && d1_in_ready) d1_acc_q.push_back(cyc + 1);
         if (d1_out_valid) begin
            check("d1_in_ready_in_done", W2'(d1_in_ready), '0);
            if (!d1_ov_prev) begin
               if (d1_exp_q.size() == 0 || d1_acc_q.size() == 0) begin
                  fail("d1_output", "out_valid with no operation outstanding");
               end else begin
                  check("d1_latency", W2'(cyc - d1_acc_q.pop_front()), W2'(LAT_D1));
                  check("d1_c", d1_c, d1_exp_q.pop_front());
               end
               d1_hold = d1_c;
            end else begin
               check("d1_c_stable", d1_c, d1_hold);
            end
         end
         d1_ov_prev = d1_out_valid;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         d32_acc_q.delete();
         d32_ov_prev = 1'b0;
      end else begin
         if (d32_in_valid && d32_in_ready) d32_acc_q.push_back(cyc + 1);
         if (d32_out_valid && !d32_ov_prev) begin
            if (d32_exp_q.size() == 0 || d32_acc_q.size() == 0) begin
               fail("d32_output", "out_valid with no operation outstanding");
            end else begin
               check("d32_latency", W2'(cyc - d32_acc_q.pop_front()), W2'(LAT_D32));
               check("d32_c", d32_c, d32_exp_q.pop_front());
            end
         end
         d32_ov_prev = d32_out_valid;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         n8_acc_q.delete();
         n8_ov_prev = 1'b0;
      end else begin
         if (n8_in_valid && n8_in_ready) n8_acc_q.push_back(cyc + 1);
         if (n8_out_valid && !n8_ov_prev) begin
            if (n8_exp_q.size() == 0 || n8_acc_q.size() == 0) begin
               fail("n8_output", "out_valid with no operation outstanding");
            end else begin
               check("n8_latency", W2'(cyc - n8_acc_q.pop_front()), W2'(LAT_N8));
               check("n8_c", W2'(n8_c), n8_exp_q.pop_front());
            end
         end
         n8_ov_prev = n8_out_valid;
      end
   end

   // Random back-pressure for the DIGIT=32 instance while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         d32_out_ready = d32_rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------------------------------------------------- stimulus ops
   // All send tasks are entered at posedge+#1 and return at posedge+#1.
   task automatic d1_send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [W2-1:0] e);
      logic ok;
      int   t;
      d1_a = a; d1_b = b; d1_in_valid = 1'b1;
      d1_exp_q.push_back(e);
      ok = 1'b0; t = 0;
      while (!ok && t < 3000) begin
         @(negedge clk); ok = d1_in_ready;
         @(posedge clk); #1; t++;
      end
      d1_in_valid = 1'b0;
      if (!ok) fail("d1_accept", "operands not accepted within 3000 cycles");
      else begin
         check("d1_busy_after_accept", W2'(d1_busy), W2'(1));
         check("d1_in_ready_after_accept", W2'(d1_in_ready), '0);
      end
   endtask

   task automatic d32_send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [W2-1:0] e);
      logic ok;
      int   t;
      d32_a = a; d32_b = b; d32_in_valid = 1'b1;
      d32_exp_q.push_back(e);
      ok = 1'b0; t = 0;
      while (!ok && t < 500) begin
         @(negedge clk); ok = d32_in_ready;
         @(posedge clk); #1; t++;
      end
      d32_in_valid = 1'b0;
      if (!ok) fail("d32_accept", "operands not accepted within 500 cycles");
   endtask

   task automatic n8_send(input logic [NS-1:0] a, input logic [NS-1:0] b, input logic [2*NS-1:0] e);
      logic ok;
      int   t;
      n8_a = a; n8_b = b; n8_in_valid = 1'b1;
      n8_exp_q.push_back(W2'(e));
      ok = 1'b0; t = 0;
      while (!ok && t < 200) begin
         @(negedge clk); ok = n8_in_ready;
         @(posedge clk); #1; t++;
      end
      n8_in_valid = 1'b0;
      if (!ok) fail("n8_accept", "operands not accepted within 200 cycles");
   endtask

   task automatic drain_all();
      int t;
      t = 0;
      while ((d1_exp_q.size() + d32_exp_q.size() + n8_exp_q.size()) != 0 && t < 3000) begin
         @(posedge clk); t++;
      end
      if ((d1_exp_q.size() + d32_exp_q.size() + n8_exp_q.size()) != 0) begin
         fail("drain", "expected results never presented within 3000 cycles");
         d1_exp_q.delete(); d32_exp_q.delete(); n8_exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      logic [W2-1:0] sq;
      logic [NB-1:0] ra, rb;
      int            t;

      repeat (3) @(posedge clk);
      #1;
      check("rst_d1_in_ready",  W2'(d1_in_ready), W2'(1));
      check("rst_d1_out_valid", W2'(d1_out_valid), '0);
      check("rst_d1_busy",      W2'(d1_busy), '0);
      check("rst_d1_c",         d1_c, '0);
      check("rst_n8_in_ready",  W2'(n8_in_ready), W2'(1));
      check("rst_d32_c",        d32_c, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // --- N=571, DIGIT=1: trivial product, full 860-cycle latency
      d1_send(bitn(0), bitn(0), bit2(0));
      drain_all();

      // --- high halves only, held under 50 cycles of back-pressure
      d1_out_ready = 1'b0;
      d1_send(bitn(570), bitn(570), bit2(1140));
      t = 0;
      while (!d1_out_valid && t < 1000) begin @(posedge clk); #1; t++; end
      if (!d1_out_valid) fail("d1_bp_wait", "out_valid not seen within 1000 cycles");
      repeat (50) @(posedge clk);
      #1;
      check("d1_bp_out_valid_held", W2'(d1_out_valid), W2'(1));
      check("d1_bp_in_ready_low",   W2'(d1_in_ready), '0);
      check("d1_bp_c_value",        d1_c, bit2(1140));
      d1_out_ready = 1'b1;
      @(posedge clk); #1;
      check("d1_release_out_valid", W2'(d1_out_valid), '0);
      check("d1_release_in_ready",  W2'(d1_in_ready), W2'(1));
      check("d1_release_busy",      W2'(d1_busy), '0);

      // --- reset in the middle of MUL_HI (cycle ~400 of 860)
      d1_send(NB'(3), NB'(3), W2'(5));
      repeat (399) @(posedge clk);
      #2;
      check("d1_busy_before_reset", W2'(d1_busy), W2'(1));
      rst = 1'b1;
      d1_exp_q.delete();
      #1;
      check("d1_reset_out_valid", W2'(d1_out_valid), '0);
      check("d1_reset_in_ready",  W2'(d1_in_ready), W2'(1));
      check("d1_reset_busy",      W2'(d1_busy), '0);
      check("d1_reset_c",         d1_c, '0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      d1_send(NB'(5), NB'(7), W2'(27));
      drain_all();

      // --- N=8, DIGIT=1 directed vectors
      n8_send(8'hFF, 8'hFF, 16'h5555);
      n8_send(8'h03, 8'h03, 16'h0005);
      n8_send(8'h80, 8'h80, 16'h4000);
      n8_send(8'h0F, 8'hF0, 16'h0550);
      n8_send(8'h00, 8'hA5, 16'h0000);
      drain_all();

      // --- N=571, DIGIT=32 directed vectors plus reference-checked pairs
      d32_rand_rdy = 1'b1;
      d32_send(NB'(5), NB'(7), W2'(27));
      d32_send(bitn(285), bitn(286), bit2(571));
      d32_send(bitn(570), bitn(570), bit2(1140));
      sq = '0;
      for (int i = 0; i < NB; i++) sq[2*i] = 1'b1;
      d32_send({NB{1'b1}}, {NB{1'b1}}, sq);
      d32_send('0, {NB{1'b1}}, '0);
      for (int n = 0; n < 30; n++) begin
         ra = rand_op();
         rb = rand_op();
         d32_send(ra, rb, clmul_ref(ra, rb));
      end
      drain_all();
      d32_rand_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

`default_nettype wire
